uart_rx_cfg: RTL and testbench
==============================

Name: uart_rx_cfg

Overview:
- Parametrised UART receiver; successor to the fixed 8N1 receiver in the console mux.
- Configurable data width, parity mode and stop-bit count.
- Adds an input synchroniser, parity/framing/overrun error reporting and a valid/ready output handshake with a one-word holding register.
- Sits between a console serial pin and the mux arbitration logic.

Parameters:
- DATA_BITS, 8: data bits per frame, legal 5..9, LSB first.
- PARITY_MODE, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: stop bits per frame, legal 1..2.
- CLK_PER_BIT, 8: clk cycles per bit, legal >= 4.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- serial  in  1  asynchronous RX line, idle high.
- data_valid  out  1  holding register holds an unconsumed word.
- data_ready  in  1  consumer accepts the word when data_valid & data_ready.
- data  out  DATA_BITS  received word, stable while data_valid=1.
- parity_err  out  1  parity mismatch on the held word (always 0 if PARITY_MODE=0).
- frame_err  out  1  a stop bit was sampled low for the held word.
- overrun  out  1  at least one frame was dropped while the word was held.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; synchroniser flops=1.
  - data_valid, parity_err, frame_err, overrun, busy all 0; data=0.
  - A frame in progress at reset is discarded.
- Synchroniser: two flops on serial; all logic uses the synchronised value s. Adds 2 cycles of latency.
- Counter: cnt, width clog2(CLK_PER_BIT)+1; bit index bidx, width 4.
- IDLE:
  - s==0 -> cnt=0, go to START.
- START:
  - At cnt==(CLK_PER_BIT-1)/2: if s==0, cnt=0, bidx=0, go to DATA; else (glitch) go to IDLE with no output.
  - Otherwise cnt++.
- DATA:
  - At cnt==CLK_PER_BIT-1: cnt=0, shift s into shift register (LSB first), bidx++.
  - After sample number DATA_BITS: go to PARITY if PARITY_MODE!=0, else STOP (bidx=0).
  - Otherwise cnt++.
- PARITY:
  - At cnt==CLK_PER_BIT-1: perr = XOR(data bits, s) != (PARITY_MODE==2). Then cnt=0, go to STOP.
- STOP:
  - At cnt==CLK_PER_BIT-1: sample s; any low stop bit sets ferr.
  - After stop sample number STOP_BITS the frame completes.
  - If ferr==0, go to IDLE at that same edge, so back-to-back frames are received with zero idle time.
  - If ferr==1, go to RECOVER.
- RECOVER:
  - Wait for s==1, then go to IDLE. This prevents a held-low line re-triggering START.
- Completion (edge after the last stop sample):
  - If data_valid==0 or data_valid&data_ready in the same cycle: load data, parity_err, frame_err; set data_valid=1; clear overrun.
  - Else: frame dropped; held data unchanged; overrun=1.
- Handshake:
  - data_valid&data_ready with no simultaneous completion -> data_valid=0, overrun=0 next cycle.
  - Error flags follow the held word; they are don't-care when data_valid=0 but are driven 0.
- Latency: from the serial edge at the middle of the last stop bit to data_valid=1 is 3 clk (2 synchroniser + 1 register).
- busy=1 in every state except IDLE.

Optional Feature:
- Macro UART_RX_BREAK_DETECT_EN.
- When defined:
  - Extra output port break_det (1 bit).
  - A frame with all data bits 0, parity bit 0 (if present) and first stop bit 0 is a break.
  - A break does not load the holding register; it pulses break_det for 1 clk at completion.
  - The FSM enters RECOVER.
  - frame_err and the held word are unaffected.
- When undefined: no break_det port; a break is reported as an ordinary frame with data=0, frame_err=1.

Test Plan:
- 8N1, CLK_PER_BIT=8, send 0xA5 with data_ready=1 -> data_valid pulses 1 clk; data=0xA5; parity_err=0, frame_err=0; busy returns 0.
- PARITY_MODE=1, send 0x03 with parity bit 1 -> data=0x03, parity_err=1. Repeat with parity bit 0 -> parity_err=0.
- 8N1, send 0x5A with stop bit 0, then line high -> data=0x5A, frame_err=1. FSM stays in RECOVER until the line goes high, then a following 0x11 is received cleanly.
- Low pulse on serial of 2 clk -> no data_valid; busy returns to 0 within CLK_PER_BIT/2+3 clk.
- data_ready=0, send 0x12 then 0x34 back-to-back -> data=0x12, overrun=1. Raise data_ready -> data_valid=0, overrun=0.
- Assert rst mid-DATA of 0xFF, release, send 0x42 -> only 0x42 delivered, with no errors. With UART_RX_BREAK_DETECT_EN, a 10-bit low line -> break_det=1 for 1 clk and data_valid stays 0.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver with input synchroniser, parity /
// framing / overrun reporting and a one-word valid/ready holding register.
// Optional feature macro: UART_RX_BREAK_DETECT_EN adds a break_det pulse output
// and keeps break frames out of the holding register.
module uart_rx_cfg #(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int CLK_PER_BIT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic [DATA_BITS-1:0] data,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
`ifdef UART_RX_BREAK_DETECT_EN
    ,
    output logic                 break_det
`endif
);

    localparam int CW = $clog2(CLK_PER_BIT) + 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_MID   = CW'((CLK_PER_BIT - 1) / 2);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic          ODD_PAR   = (PARITY_MODE == 2);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, RECOVER} state_t;

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [3:0]           bidx, bidx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 perr, perr_n;
    logic                 ferr, ferr_n;
    logic                 done;
    logic                 frame_ok;
    logic                 s_meta, s;

`ifdef UART_RX_BREAK_DETECT_EN
    // zero_run stays set while every bit from the first data bit through the
    // first stop bit has been sampled low
    logic                 zero_run, zero_n;
    logic                 brk;
`endif

    // two-flop synchroniser, idle-high so reset does not fake a start bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_meta <= 1'b1;
            s      <= 1'b1;
        end else begin
            s_meta <= serial;
            s      <= s_meta;
        end
    end

    // FSM and frame datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            bidx  <= '0;
            shreg <= '0;
            perr  <= 1'b0;
            ferr  <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            zero_run <= 1'b0;
`endif
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            bidx  <= bidx_n;
            shreg <= shreg_n;
            perr  <= perr_n;
            ferr  <= ferr_n;
`ifdef UART_RX_BREAK_DETECT_EN
            zero_run <= zero_n;
`endif
        end
    end

    // next-state: bit timing, sampling and frame completion
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bidx_n  = bidx;
        shreg_n = shreg;
        perr_n  = perr;
        ferr_n  = ferr;
        done    = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
        zero_n  = zero_run;
`endif
        case (state)
            IDLE: begin
                if (!s) begin
                    cnt_n   = '0;
                    state_n = START;
                end
            end
            START: begin
                if (cnt == CNT_MID) begin
                    if (!s) begin
                        cnt_n   = '0;
                        bidx_n  = '0;
                        perr_n  = 1'b0;
                        ferr_n  = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
                        zero_n  = 1'b1;
`endif
                        state_n = DATA;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_n   = '0;
                    shreg_n = {s, shreg[DATA_BITS-1:1]};
                    bidx_n  = bidx + 4'd1;
`ifdef UART_RX_BREAK_DETECT_EN
                    if (s) zero_n = 1'b0;
`endif
                    if (bidx == DATA_LAST) begin
                        bidx_n  = '0;
                        state_n = (PARITY_MODE != 0) ? PARITY : STOP;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            PARITY: begin
                if (cnt == CNT_LAST) begin
                    perr_n  = (^shreg) ^ s ^ ODD_PAR;
                    cnt_n   = '0;
                    state_n = STOP;
`ifdef UART_RX_BREAK_DETECT_EN
                    if (s) zero_n = 1'b0;
`endif
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_n  = '0;
                    bidx_n = bidx + 4'd1;
                    if (!s) ferr_n = 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
                    if (s && bidx == 4'd0) zero_n = 1'b0;
`endif
                    if (bidx == STOP_LAST) begin
                        done    = 1'b1;
                        bidx_n  = '0;
                        // a clean frame returns straight to IDLE so the next
                        // start bit can follow with no idle time
                        state_n = ferr_n ? RECOVER : IDLE;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RECOVER: begin
                // hold off until the line is released so a stuck-low line
                // cannot look like a fresh start bit
                if (s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
`ifdef UART_RX_BREAK_DETECT_EN
        brk      = done && zero_n;
        if (brk) state_n = RECOVER;
        frame_ok = done && !brk;
`else
        frame_ok = done;
`endif
    end

    // holding register with overrun tracking and valid/ready handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_valid <= 1'b0;
            data       <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else if (frame_ok) begin
            if (!data_valid || data_ready) begin
                data       <= shreg;
                parity_err <= perr;
                frame_err  <= ferr_n;
                data_valid <= 1'b1;
                overrun    <= 1'b0;
            end else begin
                overrun    <= 1'b1;
            end
        end else if (data_valid && data_ready) begin
            data_valid <= 1'b0;
            overrun    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end
    end

`ifdef UART_RX_BREAK_DETECT_EN
    // single-cycle break indication at frame completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) break_det <= 1'b0;
        else     break_det <= brk;
    end
`endif

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: two receivers (8N1 / 7E2) driven with directed and random
// frames; expected words are queued at send time and checked by a monitor.
module tb_uart_rx_cfg;

    localparam int DBA[2]  = '{8, 7};
    localparam int PMA[2]  = '{0, 1};
    localparam int SBA[2]  = '{1, 2};
    localparam int CPBA[2] = '{8, 5};

    typedef struct {
        int d;
        int data;
        int perr;
        int ferr;
        int ovr;
    } exp_t;

    logic       clk, rst;
    logic       ser0, ser1, rdy0, rdy1;
    logic [7:0] dat0;
    logic [6:0] dat1;
    logic [8:0] dat[2];
    logic       vld[2], perr_o[2], ferr_o[2], ovr_o[2], busy_o[2];
    logic       brk_o[2];

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   brk_exp[2] = '{0, 0};
    int   brk_seen[2] = '{0, 0};

    assign dat[0] = {1'b0, dat0};
    assign dat[1] = {2'b0, dat1};

    uart_rx_cfg #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .CLK_PER_BIT(8)) u_dut0 (
        .clk(clk), .rst(rst), .serial(ser0), .data_valid(vld[0]), .data_ready(rdy0),
        .data(dat0), .parity_err(perr_o[0]), .frame_err(ferr_o[0]), .overrun(ovr_o[0]),
        .busy(busy_o[0])
`ifdef UART_RX_BREAK_DETECT_EN
        , .break_det(brk_o[0])
`endif
    );

    uart_rx_cfg #(.DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2), .CLK_PER_BIT(5)) u_dut1 (
        .clk(clk), .rst(rst), .serial(ser1), .data_valid(vld[1]), .data_ready(rdy1),
        .data(dat1), .parity_err(perr_o[1]), .frame_err(ferr_o[1]), .overrun(ovr_o[1]),
        .busy(busy_o[1])
`ifdef UART_RX_BREAK_DETECT_EN
        , .break_det(brk_o[1])
`endif
    );

`ifndef UART_RX_BREAK_DETECT_EN
    assign brk_o[0] = 1'b0;
    assign brk_o[1] = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, queue depth %0d", q.size());
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic rdy_of(input int d);
        return (d == 0) ? rdy0 : rdy1;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input int d, input logic b);
        if (d == 0) ser0 = b;
        else        ser1 = b;
        tick(CPBA[d]);
    endtask

    // reference model: mode 0 = expect word, 1 = expect word with overrun,
    // 2 = frame is expected to be dropped
    task automatic send(input int d, input logic [8:0] val, input bit pbit,
                        input bit [1:0] stops, input int mode);
        exp_t       e;
        logic [8:0] mask;
        int         ones;
        bit         brk;
        mask   = (9'h1 << DBA[d]) - 9'h1;
        ones   = $countones(val & mask) + int'(pbit);
        e.d    = d;
        e.data = int'(val & mask);
        e.perr = (PMA[d] == 0) ? 0 : (PMA[d] == 1) ? ones % 2 : 1 - ones % 2;
        e.ferr = (!stops[0] || (SBA[d] == 2 && !stops[1])) ? 1 : 0;
        e.ovr  = (mode == 1) ? 1 : 0;
        brk    = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
        brk    = ((val & mask) == 9'h0) && (PMA[d] == 0 || !pbit) && !stops[0];
`endif
        if (brk) brk_exp[d]++;
        else if (mode != 2) q.push_back(e);
        drive_bit(d, 1'b0);
        for (int i = 0; i < DBA[d]; i++) drive_bit(d, val[i]);
        if (PMA[d] != 0) drive_bit(d, pbit);
        for (int i = 0; i < SBA[d]; i++) drive_bit(d, stops[i]);
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (q.size() != 0 && n < 1000) begin
            tick(1);
            n++;
        end
        chk(nm, q.size(), 0);
    endtask

    task automatic check_reset(input int d);
        chk($sformatf("rst_valid%0d", d), vld[d], 0);
        chk($sformatf("rst_busy%0d", d), busy_o[d], 0);
        chk($sformatf("rst_data%0d", d), dat[d], 0);
        chk($sformatf("rst_perr%0d", d), perr_o[d], 0);
        chk($sformatf("rst_ferr%0d", d), ferr_o[d], 0);
        chk($sformatf("rst_ovr%0d", d), ovr_o[d], 0);
        chk($sformatf("rst_brk%0d", d), brk_o[d], 0);
    endtask

    task automatic rand_run(input int d, input int n);
        for (int k = 0; k < n; k++) begin
            logic [8:0] v;
            bit         pb;
            bit [1:0]   st;
            int         gap;
            v     = 9'($urandom);
            if ($urandom % 10 == 0) v = 9'h0;
            pb    = 1'($urandom);
            st[0] = ($urandom % 8) != 0;
            st[1] = ($urandom % 8) != 0;
            gap   = $urandom % 3;
            if ((!st[0] || (SBA[d] == 2 && !st[1])) && gap == 0) gap = 1;
            send(d, v, pb, st, 0);
            for (int g = 0; g < gap; g++) drive_bit(d, 1'b1);
        end
    endtask

    // monitor: every accepted word must match the oldest expectation for that receiver
    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                if (vld[d] && rdy_of(d)) begin
                    int   idx;
                    exp_t e;
                    idx = -1;
                    for (int i = 0; i < q.size(); i++)
                        if (q[i].d == d && idx < 0) idx = i;
                    if (idx < 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_word dut%0d: got data %0h, expected no word", d, dat[d]);
                    end else begin
                        e = q[idx];
                        q.delete(idx);
                        chk($sformatf("data dut%0d", d), int'(dat[d]), e.data);
                        chk($sformatf("parity_err dut%0d", d), perr_o[d], e.perr);
                        chk($sformatf("frame_err dut%0d", d), ferr_o[d], e.ferr);
                        chk($sformatf("overrun dut%0d", d), ovr_o[d], e.ovr);
                    end
                end
                if (brk_o[d]) brk_seen[d]++;
            end
        end
    end

    initial begin
        rst  = 1'b1;
        ser0 = 1'b1;
        ser1 = 1'b1;
        rdy0 = 1'b1;
        rdy1 = 1'b1;
        tick(4);
        check_reset(0);
        check_reset(1);
        rst = 1'b0;
        tick(4);

        // clean 8N1 word
        send(0, 9'h0A5, 1'b0, 2'b11, 0);
        tick(8);
        drain("drain_a5");
        chk("busy_idle_a5", busy_o[0], 0);

        // even parity: wrong then right parity bit
        send(1, 9'h003, 1'b1, 2'b11, 0);
        send(1, 9'h003, 1'b0, 2'b11, 0);
        tick(5);
        drain("drain_parity");

        // framing error, line held low, then recovery
        send(0, 9'h05A, 1'b0, 2'b00, 0);
        tick(24);
        chk("busy_recover", busy_o[0], 1);
        ser0 = 1'b1;
        tick(8);
        chk("busy_after_recover", busy_o[0], 0);
        send(0, 9'h011, 1'b0, 2'b11, 0);
        tick(8);
        drain("drain_ferr");

        // short glitch must not start a frame
        ser0 = 1'b0;
        tick(2);
        ser0 = 1'b1;
        tick(CPBA[0] / 2 + 3);
        chk("busy_glitch", busy_o[0], 0);

        // overrun with consumer stalled
        rdy0 = 1'b0;
        send(0, 9'h012, 1'b0, 2'b11, 1);
        send(0, 9'h034, 1'b0, 2'b11, 2);
        tick(8);
        chk("ovr_held_valid", vld[0], 1);
        chk("ovr_held_flag", ovr_o[0], 1);
        rdy0 = 1'b1;
        tick(1);
        chk("ovr_cleared_valid", vld[0], 0);
        chk("ovr_cleared_flag", ovr_o[0], 0);
        drain("drain_ovr");

        // reset in the middle of a 0xFF frame
        drive_bit(0, 1'b0);
        ser0 = 1'b1;
        tick(20);
        rst = 1'b1;
        tick(2);
        check_reset(0);
        rst = 1'b0;
        tick(16);
        send(0, 9'h042, 1'b0, 2'b11, 0);
        tick(8);
        drain("drain_after_rst");

        // break: line low for a whole frame
        send(0, 9'h000, 1'b0, 2'b00, 0);
        ser0 = 1'b1;
        tick(16);
        drain("drain_break");

        // random traffic on both receivers at once
        fork
            rand_run(0, 30);
            rand_run(1, 30);
        join
        ser0 = 1'b1;
        ser1 = 1'b1;
        tick(20);
        drain("drain_random");
        tick(20);
        chk("break_count0", brk_seen[0], brk_exp[0]);
        chk("break_count1", brk_seen[1], brk_exp[1]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
